muldiv_unit: RTL and testbench

Multi-cycle multiply/divide unit in the execute stage, downstream of the ALU decoder. Consumes the 5-bit `alucontrol` code plus both source operands, and runs MULT, MULTU, DIV and DIVU. Produces a 64-bit `{hi, lo}` result for the HI/LO register write. Drives `busy` so the pipeline hazard unit can stall fetch, decode and execute until `done`.

---
 rtl/muldiv_unit_pkg.sv | 31 +++
 rtl/muldiv_iter.sv | 30 +++
 rtl/muldiv_unit.sv | 143 ++++++++++++++
 tb/tb_muldiv_unit.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared types and constants for the multiply/divide unit: ALU control codes,
// FSM state encoding, iteration count and the {hi, lo} result payload.
package muldiv_unit_pkg;

    localparam int unsigned DATA_W       = 32;
    localparam int unsigned CNT_W        = 5;
    localparam int unsigned MULDIV_ITERS = 32;

    localparam logic [4:0] MULT_CONTROL  = 5'b11000;
    localparam logic [4:0] MULTU_CONTROL = 5'b11001;
    localparam logic [4:0] DIV_CONTROL   = 5'b11010;
    localparam logic [4:0] DIVU_CONTROL  = 5'b11011;

    typedef enum logic [1:0] {
        MULDIV_IDLE = 2'b00,
        MULDIV_RUN  = 2'b01,
        MULDIV_DONE = 2'b10
    } muldiv_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
    } hilo_t;

    // True for the four control codes this unit acts on
    function automatic logic is_muldiv(input logic [4:0] code);
        return (code == MULT_CONTROL) || (code == MULTU_CONTROL) ||
               (code == DIV_CONTROL)  || (code == DIVU_CONTROL);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Single combinational step of the iterative datapath.
// Divide: restoring shift-subtract on {remainder, quotient}.
// Multiply: shift-add on {partial product, multiplier}.
module muldiv_iter
    import muldiv_unit_pkg::*;
(
    input  logic                  is_mul,
    input  logic [2*DATA_W-1:0]   acc,
    input  logic [DATA_W-1:0]     opnd,
    output logic [2*DATA_W-1:0]   acc_next_c
);

    logic [DATA_W:0]   top_c;
    logic [DATA_W-1:0] diff_c;
    logic [DATA_W:0]   sum_c;

    // One iteration: trial subtract for divide, conditional add + shift for multiply
    always_comb begin
        top_c      = acc[2*DATA_W-1:DATA_W-1];
        diff_c     = DATA_W'(top_c - {1'b0, opnd});
        sum_c      = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opnd} : '0);
        acc_next_c = {acc[2*DATA_W-2:0], 1'b0};
        if (is_mul) begin
            acc_next_c = {sum_c, acc[DATA_W-1:1]};
        end else if (top_c >= {1'b0, opnd}) begin
            acc_next_c = {diff_c, acc[DATA_W-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit producing {hi, lo}.
// Divides always take 32 RUN iterations. Multiplies are a registered single
// cycle `*` by default; with MULDIV_ITER_MUL_EN defined they iterate through
// RUN as shift-add on magnitudes and share the divide timing.
module muldiv_unit
    import muldiv_unit_pkg::*;
(
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic [4:0]          alucontrol,
    input  logic [DATA_W-1:0]   srca,
    input  logic [DATA_W-1:0]   srcb,
    input  logic                flush,
    output logic                busy,
    output logic                done,
    output logic [2*DATA_W-1:0] result
);

    muldiv_state_e       state, state_next;
    logic [CNT_W-1:0]    cnt;
    logic                op_div, sign_a, sign_b;
    logic [DATA_W-1:0]   a_raw, opnd;
    logic [2*DATA_W-1:0] acc, acc_next_c, result_next_c;
    logic                accept_c, code_div_c, code_signed_c, in_sign_a_c, in_sign_b_c;
    logic [DATA_W-1:0]   abs_a_c, abs_b_c;
    logic                busy_next_c, done_next_c, is_mul_c;
    hilo_t               div_res_c;

    // Decode the incoming instruction and operand magnitudes
    always_comb begin
        code_div_c    = (alucontrol == DIV_CONTROL) || (alucontrol == DIVU_CONTROL);
        code_signed_c = (alucontrol == MULT_CONTROL) || (alucontrol == DIV_CONTROL);
        in_sign_a_c   = code_signed_c & srca[DATA_W-1];
        in_sign_b_c   = code_signed_c & srcb[DATA_W-1];
        abs_a_c       = in_sign_a_c ? -srca : srca;
        abs_b_c       = in_sign_b_c ? -srcb : srcb;
        accept_c      = (state == MULDIV_IDLE) && start && !flush && is_muldiv(alucontrol);
    end

`ifndef MULDIV_ITER_MUL_EN
    logic [2*DATA_W-1:0] ext_a_c, ext_b_c, mul_prod_c;

    // Single-cycle full-width product taken straight from the inputs
    always_comb begin
        ext_a_c    = code_signed_c ? {{DATA_W{srca[DATA_W-1]}}, srca} : {{DATA_W{1'b0}}, srca};
        ext_b_c    = code_signed_c ? {{DATA_W{srcb[DATA_W-1]}}, srcb} : {{DATA_W{1'b0}}, srcb};
        mul_prod_c = ext_a_c * ext_b_c;
    end
`endif

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= MULDIV_IDLE;
        else         state <= state_next;
    end

    // Next-state logic; flush overrides everything
    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = MULDIV_IDLE;
        end else begin
            case (state)
                MULDIV_IDLE: begin
                    if (accept_c) begin
`ifdef MULDIV_ITER_MUL_EN
                        state_next = MULDIV_RUN;
`else
                        state_next = code_div_c ? MULDIV_RUN : MULDIV_DONE;
`endif
                    end
                end
                MULDIV_RUN:  if (cnt == CNT_W'(MULDIV_ITERS - 1)) state_next = MULDIV_DONE;
                MULDIV_DONE: state_next = MULDIV_IDLE;
                default:     state_next = MULDIV_IDLE;
            endcase
        end
    end

    // Output decode of the next state, registered below
    always_comb begin
        busy_next_c = (state_next == MULDIV_RUN);
        done_next_c = (state_next == MULDIV_DONE);
    end

    assign is_mul_c = !op_div;

    muldiv_iter u_iter (
        .is_mul     (is_mul_c),
        .acc        (acc),
        .opnd       (opnd),
        .acc_next_c (acc_next_c)
    );

    // Sign fixup and special cases on the final iteration value
    always_comb begin
        div_res_c.lo = (sign_a ^ sign_b) ? -acc_next_c[DATA_W-1:0] : acc_next_c[DATA_W-1:0];
        div_res_c.hi = sign_a ? -acc_next_c[2*DATA_W-1:DATA_W] : acc_next_c[2*DATA_W-1:DATA_W];
        if (opnd == '0) begin
            div_res_c.hi = a_raw;
            div_res_c.lo = '1;
        end
`ifdef MULDIV_ITER_MUL_EN
        result_next_c = op_div ? div_res_c : ((sign_a ^ sign_b) ? -acc_next_c : acc_next_c);
`else
        result_next_c = (state == MULDIV_IDLE) ? mul_prod_c : div_res_c;
`endif
    end

    // Operand latch, iteration registers and output registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt    <= '0;
            op_div <= 1'b0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            a_raw  <= '0;
            opnd   <= '0;
            acc    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            busy <= busy_next_c;
            done <= done_next_c;
            if (accept_c) begin
                cnt    <= '0;
                op_div <= code_div_c;
                sign_a <= in_sign_a_c;
                sign_b <= in_sign_b_c;
                a_raw  <= srca;
                opnd   <= code_div_c ? abs_b_c : abs_a_c;
                acc    <= {{DATA_W{1'b0}}, (code_div_c ? abs_a_c : abs_b_c)};
            end else if (state == MULDIV_RUN) begin
                cnt <= cnt + CNT_W'(1);
                acc <= acc_next_c;
            end
            if (done_next_c) result <= result_next_c;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed and randomized operations against an
// arithmetic reference model, plus flush, reset and ignored-start scenarios.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

`ifdef MULDIV_ITER_MUL_EN
    localparam int MUL_LAT = 33;
`else
    localparam int MUL_LAT = 1;
`endif
    localparam int DIV_LAT = 33;

    logic        clk;
    logic        resetn;
    logic        start;
    logic [4:0]  alucontrol;
    logic [31:0] srca, srcb;
    logic        flush;
    logic        busy, done;
    logic [63:0] result;

    int          vectors = 0;
    int          miscompares = 0;
    logic [63:0] last_res;

    muldiv_unit dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .alucontrol (alucontrol),
        .srca       (srca),
        .srcb       (srcb),
        .flush      (flush),
        .busy       (busy),
        .done       (done),
        .result     (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference: {hi, lo} from plain integer arithmetic
    function automatic logic [63:0] ref_model(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b);
        int       ia, ib, q, r;
        longint   la, lb;
        longint unsigned ua, ub;
        ia = a; ib = b;
        if (code == DIVU_CONTROL) begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
        end else if (code == DIV_CONTROL) begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            q = ia / ib;
            r = ia % ib;
            return {32'(r), 32'(q)};
        end else if (code == MULT_CONTROL) begin
            la = ia; lb = ib;
            return 64'(la * lb);
        end
        ua = {32'h0, a}; ub = {32'h0, b};
        return 64'(ua * ub);
    endfunction

    function automatic int lat_of(input logic [4:0] code);
        return (code == DIV_CONTROL || code == DIVU_CONTROL) ? DIV_LAT : MUL_LAT;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Present one start for one edge, then scramble inputs to prove latching
    task automatic issue(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b);
        alucontrol = code; srca = a; srcb = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; alucontrol = 5'($urandom); srca = $urandom; srcb = $urandom;
    endtask

    // Record busy/done activity from cycle first_cyc until one cycle past done
    task automatic observe(input int first_cyc, input int limit, output int done_cyc, output logic [63:0] res,
                           output int busy_first, output int busy_last, output int busy_cnt,
                           output logic done_after, output logic [63:0] res_after);
        done_cyc = 0; res = '0; busy_first = 0; busy_last = 0; busy_cnt = 0;
        done_after = 1'b0; res_after = '0;
        for (int cyc = first_cyc; cyc <= limit; cyc++) begin
            if (busy) begin
                if (busy_first == 0) busy_first = cyc;
                busy_last = cyc;
                busy_cnt++;
            end
            if (done && done_cyc == 0) begin
                done_cyc = cyc;
                res = result;
            end
            @(posedge clk); #1;
            if (done_cyc != 0) begin
                done_after = done;
                res_after = result;
                break;
            end
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; start = 1'b0; flush = 1'b0; alucontrol = '0; srca = '0; srcb = '0;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset busy: got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset done: got %b want 0", done); end
        vectors++; if (result !== 64'h0) begin miscompares++; $display("FAIL reset result: got %h want 0", result); end
        resetn = 1'b1;
        @(posedge clk); #1;
        last_res = '0;
    endtask

    // Directed table; each entry is issued in the cycle right after the previous DONE
    task automatic test_directed_back_to_back();
        logic [4:0]  codes [10] = '{DIVU_CONTROL, DIV_CONTROL, DIV_CONTROL, DIVU_CONTROL, DIV_CONTROL,
                                    DIV_CONTROL, MULT_CONTROL, MULTU_CONTROL, MULT_CONTROL, MULTU_CONTROL};
        logic [31:0] as [10] = '{32'd100, 32'hFFFF_FFF9, 32'h1234_5678, 32'h1234_5678, 32'h8000_0000,
                                 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] bs [10] = '{32'd7, 32'd2, 32'h0, 32'h0, 32'hFFFF_FFFF,
                                 32'hFFFF_FFFE, 32'd2, 32'd2, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [63:0] exps [10] = '{64'h0000_0002_0000_000E, 64'hFFFF_FFFF_FFFF_FFFD,
                                   64'h1234_5678_FFFF_FFFF, 64'h1234_5678_FFFF_FFFF,
                                   64'h0000_0000_8000_0000, 64'h0000_0001_FFFF_FFFD,
                                   64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0001_FFFF_FFFE,
                                   64'h4000_0000_0000_0000, 64'hFFFF_FFFE_0000_0001};
        string names [10] = '{"divu_100_7", "div_m7_2", "div_by_zero", "divu_by_zero", "div_overflow",
                              "div_7_m2", "mult_m1_2", "multu_m1_2", "mult_min_min", "multu_max_max"};
        for (int i = 0; i < 10; i++) begin
            int dc, bf, bl, bc, lat, ebf, ebl;
            logic [63:0] r, ra;
            logic da;
            lat = lat_of(codes[i]);
            ebf = (lat > 1) ? 1 : 0;
            ebl = (lat > 1) ? 32 : 0;
            issue(codes[i], as[i], bs[i]);
            observe(1, 40, dc, r, bf, bl, bc, da, ra);
            vectors++; if (dc !== lat) begin miscompares++; $display("FAIL %s done cycle: got %0d want %0d", names[i], dc, lat); end
            vectors++; if (r !== exps[i]) begin miscompares++; $display("FAIL %s result: got %h want %h", names[i], r, exps[i]); end
            vectors++;
            if (bf !== ebf || bl !== ebl || bc !== ebl) begin
                miscompares++;
                $display("FAIL %s busy window: got first=%0d last=%0d count=%0d want first=%0d last=%0d count=%0d",
                         names[i], bf, bl, bc, ebf, ebl, ebl);
            end
            vectors++;
            if (da !== 1'b0 || ra !== exps[i]) begin
                miscompares++;
                $display("FAIL %s pulse/hold: got done=%b result=%h want done=0 result=%h", names[i], da, ra, exps[i]);
            end
            last_res = exps[i];
        end
    endtask

    task automatic test_random();
        logic [4:0] codes [4] = '{MULT_CONTROL, MULTU_CONTROL, DIV_CONTROL, DIVU_CONTROL};
        for (int i = 0; i < 24; i++) begin
            int dc, bf, bl, bc, lat, ebl;
            logic [63:0] r, ra, exp_r;
            logic [31:0] a, b;
            logic [4:0]  code;
            logic da;
            code = codes[$urandom_range(0, 3)];
            a = pick_operand();
            b = pick_operand();
            exp_r = ref_model(code, a, b);
            lat = lat_of(code);
            ebl = (lat > 1) ? 32 : 0;
            issue(code, a, b);
            observe(1, 40, dc, r, bf, bl, bc, da, ra);
            vectors++; if (dc !== lat) begin miscompares++; $display("FAIL rand%0d done cycle: got %0d want %0d", i, dc, lat); end
            vectors++;
            if (r !== exp_r) begin
                miscompares++;
                $display("FAIL rand%0d result op=%b a=%h b=%h: got %h want %h", i, code, a, b, r, exp_r);
            end
            vectors++; if (bc !== ebl) begin miscompares++; $display("FAIL rand%0d busy count: got %0d want %0d", i, bc, ebl); end
            vectors++; if (da !== 1'b0) begin miscompares++; $display("FAIL rand%0d done pulse: got %b want 0", i, da); end
            last_res = exp_r;
        end
    endtask

    task automatic test_ignored_codes();
        for (int i = 0; i < 6; i++) begin
            logic [4:0] code;
            logic active;
            code = 5'($urandom);
            if (is_muldiv(code)) code = 5'b00000;
            alucontrol = code; srca = $urandom; srcb = $urandom | 32'h1; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            active = 1'b0;
            for (int c = 0; c < 3; c++) begin
                active = active | busy | done;
                @(posedge clk); #1;
            end
            vectors++; if (active !== 1'b0) begin miscompares++; $display("FAIL ignored code %b: got activity=%b want 0", code, active); end
            vectors++; if (result !== last_res) begin miscompares++; $display("FAIL ignored code %b result: got %h want %h", code, result, last_res); end
        end
    endtask

    task automatic test_start_while_busy();
        int dc, bf, bl, bc;
        logic [63:0] r, ra;
        logic da;
        issue(DIVU_CONTROL, 32'd1000, 32'd7);
        for (int c = 1; c <= 5; c++) begin
            alucontrol = MULT_CONTROL; srca = $urandom; srcb = $urandom; start = 1'b1;
            @(posedge clk); #1;
        end
        start = 1'b0;
        observe(6, 40, dc, r, bf, bl, bc, da, ra);
        vectors++; if (dc !== DIV_LAT) begin miscompares++; $display("FAIL busy_start done cycle: got %0d want %0d", dc, DIV_LAT); end
        vectors++; if (r !== 64'h0000_0006_0000_008E) begin miscompares++; $display("FAIL busy_start result: got %h want %h", r, 64'h0000_0006_0000_008E); end
        last_res = 64'h0000_0006_0000_008E;
    endtask

    task automatic test_flush();
        int dc, bf, bl, bc;
        logic [63:0] r, ra;
        logic da, early, active;
        issue(DIV_CONTROL, $urandom, $urandom | 32'h1);
        early = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            early = early | done;
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL flush busy: got %b want 0", busy); end
        vectors++; if ((done | early) !== 1'b0) begin miscompares++; $display("FAIL flush done: got %b want 0", done | early); end
        vectors++; if (result !== last_res) begin miscompares++; $display("FAIL flush result: got %h want %h", result, last_res); end
        issue(DIVU_CONTROL, 32'd1000, 32'd9);
        observe(1, 40, dc, r, bf, bl, bc, da, ra);
        vectors++; if (dc !== DIV_LAT) begin miscompares++; $display("FAIL post_flush done cycle: got %0d want %0d", dc, DIV_LAT); end
        vectors++; if (r !== 64'h0000_0001_0000_006F) begin miscompares++; $display("FAIL post_flush result: got %h want %h", r, 64'h0000_0001_0000_006F); end
        last_res = 64'h0000_0001_0000_006F;
        alucontrol = DIVU_CONTROL; srca = 32'd50; srcb = 32'd3; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        active = 1'b0;
        for (int c = 0; c < 36; c++) begin
            active = active | busy | done;
            @(posedge clk); #1;
        end
        vectors++; if (active !== 1'b0) begin miscompares++; $display("FAIL flush_with_start activity: got %b want 0", active); end
        vectors++; if (result !== last_res) begin miscompares++; $display("FAIL flush_with_start result: got %h want %h", result, last_res); end
    endtask

    task automatic test_reset_mid();
        int dc, bf, bl, bc;
        logic [63:0] r, ra, exp_r;
        logic [31:0] a, b;
        logic da;
        issue(DIVU_CONTROL, $urandom, $urandom | 32'h1);
        repeat (14) @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_reset busy: got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL mid_reset done: got %b want 0", done); end
        vectors++; if (result !== 64'h0) begin miscompares++; $display("FAIL mid_reset result: got %h want 0", result); end
        last_res = '0;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        a = pick_operand();
        b = $urandom;
        exp_r = ref_model(DIV_CONTROL, a, b);
        issue(DIV_CONTROL, a, b);
        observe(1, 40, dc, r, bf, bl, bc, da, ra);
        vectors++; if (dc !== DIV_LAT) begin miscompares++; $display("FAIL post_reset done cycle: got %0d want %0d", dc, DIV_LAT); end
        vectors++; if (r !== exp_r) begin miscompares++; $display("FAIL post_reset result a=%h b=%h: got %h want %h", a, b, r, exp_r); end
        last_res = exp_r;
    endtask

    initial begin
        test_reset();
        test_directed_back_to_back();
        test_random();
        test_ignored_codes();
        test_start_while_busy();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
